// File: rtl/usage_timer_pkg.sv
// Shared encodings and constants for the hood usage timer.
package usage_timer_pkg;

  // Debug-visible FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  localparam int unsigned TW             = 20;      // total_sec width
  localparam int unsigned SAT_SEC        = 359999;  // 99:59:59
  localparam int unsigned DEF_THRESH_SEC = 36000;   // 10 h reminder

endpackage

// File: rtl/usage_timer_sec_prescaler.sv
// Divides the system clock down to one-second ticks. The count is held
// while disabled so a partial second survives fan drop-outs.
module usage_timer_sec_prescaler #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;

  // Wrap is combinational so the owner can register its effects on the same edge
  assign o_tick = i_en && (r_cnt == LAST);

  // Cycle counter: clear dominates, otherwise count only when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/usage_timer.sv
// Range-hood exhaust usage timer: accumulates fan-running seconds,
// splits them into hh:mm:ss, saturates at 99:59:59 and raises a
// cleaning reminder once a programmable threshold is reached.
module usage_timer
  import usage_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DEF_THRESH = DEF_THRESH_SEC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_is_on,
  input  logic          i_busy,
  input  logic          i_clean_key,
  input  logic          i_thresh_load,
  input  logic [TW-1:0] i_thresh_in,
  output logic [TW-1:0] o_total_sec,
  output logic [6:0]    o_hh,
  output logic [5:0]    o_mm,
  output logic [5:0]    o_ss,
  output logic          o_sec_tick,
  output logic          o_reminder,
  output logic [1:0]    o_state
);

  state_e        r_state;
  logic [TW-1:0] r_total, r_thresh;
  logic [6:0]    r_hh;
  logic [5:0]    r_mm, r_ss;
  logic          r_sec_tick, r_reminder;

  logic          w_clean, w_wrap, w_sat, w_inc, w_to_full;
  logic [TW-1:0] w_total_nxt;
  logic [6:0]    w_hh_nxt;
  logic [5:0]    w_mm_nxt, w_ss_nxt;

  // Cleaning is only honoured with the fan stopped
  assign w_clean   = i_clean_key && !i_busy;
  // The next second would roll hh to 100 or overflow total_sec
  assign w_sat     = (r_hh == 7'd99 && r_mm == 6'd59 && r_ss == 6'd59) ||
                     (r_total == {TW{1'b1}});
  assign w_to_full = w_wrap && w_sat && !w_clean;
  assign w_inc     = w_wrap && !w_sat && !w_clean;

  usage_timer_sec_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_state == ST_COUNT),
    .i_clr  (w_clean),
    .o_tick (w_wrap)
  );

  // Next counter values: clear beats increment; entering FULL pins 99:59:59
  always_comb begin
    w_total_nxt = r_total;
    w_hh_nxt    = r_hh;
    w_mm_nxt    = r_mm;
    w_ss_nxt    = r_ss;
    if (w_clean) begin
      w_total_nxt = '0;
      w_hh_nxt    = '0;
      w_mm_nxt    = '0;
      w_ss_nxt    = '0;
    end else if (w_to_full) begin
      w_total_nxt = TW'(SAT_SEC);
      w_hh_nxt    = 7'd99;
      w_mm_nxt    = 6'd59;
      w_ss_nxt    = 6'd59;
    end else if (w_inc) begin
      w_total_nxt = r_total + TW'(1);
      if (r_ss == 6'd59) begin
        w_ss_nxt = '0;
        if (r_mm == 6'd59) begin
          w_mm_nxt = '0;
          w_hh_nxt = r_hh + 7'd1;
        end else begin
          w_mm_nxt = r_mm + 6'd1;
        end
      end else begin
        w_ss_nxt = r_ss + 6'd1;
      end
    end
  end

  // Operating-state FSM; clean returns to IDLE from anywhere, FULL ignores busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (w_clean) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_is_on && i_busy) r_state <= ST_COUNT;
        ST_COUNT: if (w_to_full)            r_state <= ST_FULL;
                  else if (!i_is_on || !i_busy) r_state <= ST_IDLE;
        ST_FULL:  r_state <= ST_FULL;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Accumulated time and the per-second pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total    <= '0;
      r_hh       <= '0;
      r_mm       <= '0;
      r_ss       <= '0;
      r_sec_tick <= 1'b0;
    end else begin
      r_total    <= w_total_nxt;
      r_hh       <= w_hh_nxt;
      r_mm       <= w_mm_nxt;
      r_ss       <= w_ss_nxt;
      r_sec_tick <= w_inc;
    end
  end

  // Threshold register; zero would be meaningless, so it becomes one second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_thresh <= TW'(DEF_THRESH);
    else if (i_thresh_load) r_thresh <= (i_thresh_in == '0) ? TW'(1) : i_thresh_in;
  end

  // Sticky reminder, compared against the already-registered threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_reminder <= 1'b0;
    else if (w_clean) r_reminder <= 1'b0;
    else              r_reminder <= r_reminder || (w_total_nxt >= r_thresh);
  end

  assign o_total_sec = r_total;
  assign o_hh        = r_hh;
  assign o_mm        = r_mm;
  assign o_ss        = r_ss;
  assign o_sec_tick  = r_sec_tick;
  assign o_reminder  = r_reminder;
  assign o_state     = r_state;

endmodule

// File: tb/tb_usage_timer.sv
// Directed bench for usage_timer with a 10-cycle second.
module tb_usage_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        is_on, busy, clean_key, thresh_load;
  logic [19:0] thresh_in;
  logic [19:0] total_sec;
  logic [6:0]  hh;
  logic [5:0]  mm, ss;
  logic        sec_tick, reminder;
  logic [1:0]  state;

  int n_chk = 0;
  int n_err = 0;
  int idx   = 0;
  int n_tk  = 0;
  int tk [8];

  usage_timer #(.CLK_HZ(10)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_is_on       (is_on),
    .i_busy        (busy),
    .i_clean_key   (clean_key),
    .i_thresh_load (thresh_load),
    .i_thresh_in   (thresh_in),
    .o_total_sec   (total_sec),
    .o_hh          (hh),
    .o_mm          (mm),
    .o_ss          (ss),
    .o_sec_tick    (sec_tick),
    .o_reminder    (reminder),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge and logging tick positions
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      idx++;
      if (sec_tick === 1'b1) begin
        if (n_tk < 8) tk[n_tk] = idx;
        n_tk++;
      end
    end
  endtask

  task automatic clr_tk();
    idx  = 0;
    n_tk = 0;
    for (int i = 0; i < 8; i++) tk[i] = -1;
  endtask

  task automatic clean_pulse();
    clean_key = 1'b1;
    step(1);
    clean_key = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; is_on = 1'b0; busy = 1'b0;
    clean_key = 1'b0; thresh_load = 1'b0; thresh_in = '0;
    clr_tk();
    repeat (2) @(negedge clk);
    chk("rst_total", total_sec, 0);
    chk("rst_hms", {hh, mm, ss}, 0);
    chk("rst_tick", sec_tick, 0);
    chk("rst_rem", reminder, 0);
    chk("rst_state", state, 0);
    chk("rst_thresh", dut.r_thresh, 36000);
    rst_n = 1'b1;
    step(1);

    // Continuous run: COUNT entered on edge 1, ticks on the 10th/20th/30th COUNT cycle
    is_on = 1'b1; busy = 1'b1;
    clr_tk();
    step(35);
    chk("run_ntick", n_tk, 3);
    chk("run_tk0", tk[0], 11);
    chk("run_tk1", tk[1], 21);
    chk("run_tk2", tk[2], 31);
    chk("run_total", total_sec, 3);
    chk("run_ss", ss, 3);
    chk("run_state", state, 1);
    // Power-off keeps the accumulated time
    is_on = 1'b0;
    step(3);
    chk("off_state", state, 0);
    chk("off_total", total_sec, 3);
    busy = 1'b0;
    clean_pulse();
    chk("clr1_total", total_sec, 0);

    // Drop-out: 6 + 4 COUNT cycles across a 20-cycle gap make one second
    is_on = 1'b1;
    clr_tk();
    busy = 1'b1; step(6);
    busy = 1'b0; step(20);
    chk("gap_total0", total_sec, 0);
    busy = 1'b1; step(4);
    busy = 1'b0; step(1);
    chk("gap_total1", total_sec, 1);
    chk("gap_ntick", n_tk, 1);
    chk("gap_tk0", tk[0], 31);
    clean_pulse();

    // Reminder at threshold 2
    thresh_in = 20'd2; thresh_load = 1'b1;
    step(1);
    thresh_load = 1'b0;
    busy = 1'b1;
    step(20);
    chk("rem_total1", total_sec, 1);
    chk("rem_low", reminder, 0);
    step(1);
    chk("rem_total2", total_sec, 2);
    chk("rem_rise", reminder, 1);
    step(4);
    chk("rem_hold", reminder, 1);
    clean_pulse();  // busy still high: ignored
    chk("busyclr_total", total_sec, 2);
    chk("busyclr_rem", reminder, 1);
    chk("busyclr_state", state, 1);
    busy = 1'b0;
    step(1);
    clean_pulse();
    chk("clr2_total", total_sec, 0);
    chk("clr2_rem", reminder, 0);
    chk("clr2_state", state, 0);

    // Clean on the wrap cycle: clear wins, no tick
    clr_tk();
    busy = 1'b1;
    step(10);
    chk("pre9_cnt", dut.u_presc.r_cnt, 9);
    busy = 1'b0;
    clean_pulse();
    chk("race_total", total_sec, 0);
    chk("race_ntick", n_tk, 0);
    chk("race_cnt", dut.u_presc.r_cnt, 0);
    chk("race_state", state, 0);
    clr_tk();
    busy = 1'b1;
    step(11);
    chk("race_next_tk", tk[0], 11);
    chk("race_next_total", total_sec, 1);
    busy = 1'b0;
    step(1);
    clean_pulse();

    // Saturation from a preloaded 99:59:58
    force dut.r_total = 20'd359998;
    force dut.r_hh    = 7'd99;
    force dut.r_mm    = 6'd59;
    force dut.r_ss    = 6'd58;
    step(1);
    release dut.r_total;
    release dut.r_hh;
    release dut.r_mm;
    release dut.r_ss;
    chk("pre_total", total_sec, 359998);
    clr_tk();
    busy = 1'b1;
    step(30);
    chk("full_ntick", n_tk, 1);
    chk("full_total", total_sec, 359999);
    chk("full_hms", {hh, mm, ss}, {7'd99, 6'd59, 6'd59});
    chk("full_state", state, 2);
    chk("full_tick", sec_tick, 0);
    busy = 1'b0;
    step(2);
    chk("full_hold", state, 2);
    // Clean together with a zero threshold load: both land
    thresh_in = 20'd0; thresh_load = 1'b1;
    clean_pulse();
    thresh_load = 1'b0;
    chk("fclr_state", state, 0);
    chk("fclr_total", total_sec, 0);
    chk("fclr_hms", {hh, mm, ss}, 0);
    chk("thresh0_as1", dut.r_thresh, 1);

    // Threshold 1 reminder, then async reset with prescaler at 7
    clr_tk();
    busy = 1'b1;
    step(11);
    chk("t1_total", total_sec, 1);
    chk("t1_rem", reminder, 1);
    step(7);
    chk("pre7_cnt", dut.u_presc.r_cnt, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_total", total_sec, 0);
    chk("arst_rem", reminder, 0);
    chk("arst_state", state, 0);
    chk("arst_cnt", dut.u_presc.r_cnt, 0);
    chk("arst_thresh", dut.r_thresh, 36000);
    @(negedge clk);
    rst_n = 1'b1;
    clr_tk();
    step(11);
    chk("post_tk0", tk[0], 11);
    chk("post_total", total_sec, 1);
    chk("post_rem", reminder, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
